// File: rtl/prog_loader_if.sv
// prog_loader_if: byte-stream input, RAM write port and CPU control bundle for prog_loader
//   in_valid/in_data/in_ready : valid/ready byte stream from the boot source
//   ram_addr/ram_data/ram_wren : registered RAM write port
//   cpu_run/cpu_halt           : CPU stage control
//   busy/done/error/loaded     : loader status
interface prog_loader_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic [7:0] ram_addr;
    logic [7:0] ram_data;
    logic       ram_wren;
    logic       cpu_run;
    logic       cpu_halt;
    logic       busy;
    logic       done;
    logic       error;
    logic [8:0] loaded;
    modport master (
        output in_valid, in_data,
        input  in_ready, ram_addr, ram_data, ram_wren, cpu_run, cpu_halt, busy, done, error, loaded
    );
    modport slave (
        input  in_valid, in_data,
        output in_ready, ram_addr, ram_data, ram_wren, cpu_run, cpu_halt, busy, done, error, loaded
    );
endinterface

// File: rtl/prog_loader.sv
// prog_loader: receives a MAGIC/len/payload/checksum frame and writes it to RAM, then starts the CPU
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : prog_loader_if.slave (byte stream in, RAM write port, CPU run/halt, status out)
module prog_loader #(
    parameter logic [7:0] BASE_ADDR = 8'h00,
    parameter logic [7:0] MAGIC     = 8'hA5
) (
    input  logic          clk,
    input  logic          rst,
    prog_loader_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, LEN, DATA, CSUM, START, ERR} state_t;
    state_t     state_q;
    logic [8:0] len_q, idx_q, idx_d, loaded_q;
    logic [7:0] sum_q, addr_q, data_q;
    logic       wren_q, done_q, error_q, take;
    // START is the only state that refuses a byte; reset also blocks acceptance
    assign bus.in_ready = ~rst & (state_q != START);
    assign take         = bus.in_valid & bus.in_ready;
    assign idx_d        = idx_q + 9'd1;
    assign bus.ram_addr = addr_q;
    assign bus.ram_data = data_q;
    assign bus.ram_wren = wren_q;
    assign bus.cpu_run  = state_q == START;
    assign bus.cpu_halt = state_q inside {LEN, DATA, CSUM, ERR};
    assign bus.busy     = state_q inside {LEN, DATA, CSUM, START};
    assign bus.done     = done_q;
    assign bus.error    = error_q;
    assign bus.loaded   = loaded_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            len_q    <= '0;
            idx_q    <= '0;
            sum_q    <= '0;
            loaded_q <= '0;
            addr_q   <= BASE_ADDR;
            data_q   <= '0;
            wren_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            wren_q <= 1'b0;
            case (state_q)
                IDLE, ERR: if (take && bus.in_data == MAGIC) begin
                    state_q  <= LEN;
                    done_q   <= 1'b0;
                    error_q  <= 1'b0;
                    loaded_q <= '0;
                end
                LEN: if (take) begin
                    // a length byte of zero encodes a full 256-byte image
                    len_q   <= {bus.in_data == 8'd0, bus.in_data};
                    sum_q   <= '0;
                    idx_q   <= '0;
                    state_q <= DATA;
                end
                DATA: if (take) begin
                    wren_q   <= 1'b1;
                    addr_q   <= BASE_ADDR + idx_q[7:0];
                    data_q   <= bus.in_data;
                    sum_q    <= sum_q + bus.in_data;
                    idx_q    <= idx_d;
                    loaded_q <= loaded_q + 9'd1;
                    if (idx_d == len_q) state_q <= CSUM;
                end
                CSUM: if (take) begin
                    if (bus.in_data == sum_q) begin
                        state_q <= START;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= ERR;
                        error_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: randomized frame-level scoreboard bench for prog_loader
module tb_prog_loader;
    localparam logic [7:0] BASE  = 8'hF0;
    localparam logic [7:0] MAGIC = 8'hA5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    prog_loader_if bus ();

    prog_loader #(.BASE_ADDR(BASE), .MAGIC(MAGIC)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit thr = 0;
    logic [7:0]  pl[$];
    logic [15:0] wq[$];
    int          rq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic gap();
        if (thr) repeat ($urandom_range(0, 3)) tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        int  tries = 0;
        logic acc;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        do begin
            @(negedge clk);
            acc = bus.in_ready;
            tick();
            tries++;
        end while (!acc && tries < 8);
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL accept_timeout actual=not_accepted required=accepted byte=%0h", b);
        end
        bus.in_valid = 1'b0;
    endtask

    // Frame-level model: payload i lands at BASE+i; the run pulse is expected only for a correct checksum.
    task automatic send_frame(input int delta);
        int n = pl.size();
        logic [7:0] s = 8'd0;
        foreach (pl[i]) s += pl[i];
        send_byte(MAGIC);
        chk("halt_after_magic", bus.cpu_halt, 1);
        chk("busy_after_magic", bus.busy, 1);
        chk("loaded_cleared", bus.loaded, 0);
        chk("flags_cleared", {bus.done, bus.error}, 0);
        gap();
        send_byte(8'(n));
        gap();
        foreach (pl[i]) begin
            wq.push_back({8'(BASE + 8'(i)), pl[i]});
            send_byte(pl[i]);
            gap();
        end
        if (delta == 0) rq.push_back(n);
        send_byte(s + 8'(delta));
        if (delta == 0) begin
            chk("start_run", bus.cpu_run, 1);
            chk("start_halt", bus.cpu_halt, 0);
            chk("start_done_err", {bus.done, bus.error}, 2'b10);
            chk("start_loaded", bus.loaded, n);
        end else begin
            chk("err_halt", bus.cpu_halt, 1);
            chk("err_busy", bus.busy, 0);
            chk("err_done_err", {bus.done, bus.error}, 2'b01);
            chk("err_loaded", bus.loaded, n);
        end
        gap();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("ready_in_reset", bus.in_ready, 0);
        tick();
        rst = 1'b0;
        #1;
        chk("rst_ready", bus.in_ready, 1);
        chk("rst_wren", bus.ram_wren, 0);
        chk("rst_addr", bus.ram_addr, BASE);
        chk("rst_data", bus.ram_data, 0);
        chk("rst_ctl", {bus.cpu_run, bus.cpu_halt, bus.busy, bus.done, bus.error}, 0);
        chk("rst_loaded", bus.loaded, 0);
    endtask

    logic [15:0] exp_w;
    int          exp_n;
    always @(negedge clk) begin
        if (bus.ram_wren) begin
            if (wq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual=%0h required=none", {bus.ram_addr, bus.ram_data});
            end else begin
                exp_w = wq.pop_front();
                chk("ram_write", {bus.ram_addr, bus.ram_data}, exp_w);
            end
        end
        if (bus.cpu_run) begin
            if (rq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_run actual=1 required=0 loaded=%0d", bus.loaded);
            end else begin
                exp_n = rq.pop_front();
                chk("run_loaded", bus.loaded, exp_n);
            end
        end
        if (!rst) chk("ready_low_only_in_start", bus.in_ready, !bus.cpu_run);
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        tick();
        do_reset();
        // nominal frame, back-to-back
        pl = '{8'h11, 8'h22, 8'h33};
        send_frame(0);
        // bad checksum then recovery frame
        pl = '{8'h10, 8'h20};
        send_frame(1);
        repeat (3) tick();
        chk("err_sticky", {bus.error, bus.cpu_halt, bus.cpu_run}, 3'b110);
        pl = '{8'h07};
        send_frame(0);
        tick();
        chk("recover_idle", {bus.done, bus.error, bus.cpu_halt, bus.busy}, 4'b1000);
        // garbage before frame
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h5A);
        chk("garbage_dropped", {bus.busy, bus.cpu_halt, bus.ram_wren}, 0);
        pl = '{8'h42};
        send_frame(0);
        // 256-byte frame wraps the address from FF to 00
        pl.delete();
        for (int i = 0; i < 256; i++) pl.push_back(8'(i));
        send_frame(0);
        tick();
        chk("len256_loaded", bus.loaded, 256);
        // reset mid-DATA, with a MAGIC byte presented during reset that must be ignored
        send_byte(MAGIC);
        send_byte(8'h04);
        wq.push_back({BASE, 8'hAA});
        send_byte(8'hAA);
        wq.push_back({8'(BASE + 8'd1), 8'hBB});
        send_byte(8'hBB);
        bus.in_valid = 1'b1;
        bus.in_data  = MAGIC;
        do_reset();
        bus.in_valid = 1'b0;
        pl = '{8'h5C, 8'hC5};
        send_frame(0);
        // throttled random frames
        thr = 1;
        for (int f = 0; f < 10; f++) begin
            pl.delete();
            repeat ($urandom_range(1, 24)) pl.push_back(8'($urandom));
            send_frame(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 255)) : 0);
        end
        thr = 0;
        pl = '{8'h01, 8'h02};
        send_frame(0);
        repeat (3) tick();
        chk("final_idle", {bus.busy, bus.cpu_halt, bus.done}, 3'b001);
        chk("writes_drained", wq.size(), 0);
        chk("runs_drained", rq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
